// File: rtl/instruction_sequencer.sv
// Four-state fetch/decode/execute/halt sequencer driving a one-hot control word.
// Optional EXECUTE timeout abort is built in when SEQ_TIMEOUT_EN is defined.
module instruction_sequencer #(
  parameter int PC_W         = 8,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [7:0]      instr_data,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [13:0]     ctrl,
  output logic            exec_valid,
  input  logic            exec_done,
  input  logic            resume,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  instr_q;
  logic [3:0]  opcode;
  logic [13:0] dec_ctrl;
  logic        dec_illegal;

  assign opcode      = instr_q[7:4];
  assign instr_ready = (state == FETCH);

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      4'h9, 4'hE: dec_illegal  = 1'b1;
      4'hA:       dec_ctrl[9]  = 1'b1;
      4'hB:       dec_ctrl[10] = 1'b1;
      4'hC:       dec_ctrl[11] = 1'b1;
      4'hD:       dec_ctrl[12] = 1'b1;
      4'hF:       dec_ctrl[13] = 1'b1;
      default:    dec_ctrl[opcode] = 1'b1;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
  logic [TO_W-1:0] exec_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      ctrl       <= '0;
      exec_valid <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      instr_q    <= '0;
`ifdef SEQ_TIMEOUT_EN
      exec_cnt   <= '0;
`endif
    end else begin
      illegal <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            instr_q <= instr_data;
            state   <= DECODE;
          end
        end
        DECODE: begin
`ifdef SEQ_TIMEOUT_EN
          exec_cnt <= '0;
`endif
          if (dec_illegal) begin
            illegal <= 1'b1;
            pc      <= pc + 1'b1;
            state   <= FETCH;
          end else if (opcode == 4'hF) begin
            // ctrl[13] is visible only in the first HALT cycle
            ctrl   <= dec_ctrl;
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            ctrl       <= dec_ctrl;
            exec_valid <= 1'b1;
            state      <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (exec_done) begin
            ctrl       <= '0;
            exec_valid <= 1'b0;
            pc         <= (opcode == 4'hB) ? PC_W'(instr_q[3:0]) : pc + 1'b1;
            state      <= FETCH;
          end
`ifdef SEQ_TIMEOUT_EN
          // exec_done above wins over a coincident timeout
          else if (exec_cnt == TO_W'(EXEC_TIMEOUT - 1)) begin
            ctrl       <= '0;
            exec_valid <= 1'b0;
            illegal    <= 1'b1;
            pc         <= pc + 1'b1;
            state      <= FETCH;
          end else begin
            exec_cnt <= exec_cnt + 1'b1;
          end
`endif
        end
        HALT: begin
          ctrl <= '0;
          if (resume) begin
            halted <= 1'b0;
            pc     <= pc + 1'b1;
            state  <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: hand-computed expectations checked
// with immediate assertions; the timeout branch follows SEQ_TIMEOUT_EN.
module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic [7:0] pc;
  logic [13:0] ctrl;
  logic       exec_valid;
  logic       exec_done;
  logic       resume;
  logic       halted;
  logic       illegal;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [7:0]  exp_pc;

  instruction_sequencer #(.PC_W(8), .EXEC_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .pc          (pc),
    .ctrl        (ctrl),
    .exec_valid  (exec_valid),
    .exec_done   (exec_done),
    .resume      (resume),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in FETCH and returns just after the DECODE edge.
  task automatic issue(input logic [7:0] data);
    instr_valid = 1'b1;
    instr_data  = data;
    tick();
    instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0;
    exec_done = 1'b0; resume = 1'b0;
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_pc", pc, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_outs", {exec_valid, halted, illegal}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", instr_ready, 1);
    exp_pc = 8'h00;

    // opcode 3, exec_done one cycle after exec_valid
    instr_valid = 1'b1; instr_data = 8'h30;
    tick();
    instr_valid = 1'b0;
    check("decode_not_ready", instr_ready, 0);
    tick();
    check("op3_ctrl", ctrl, 14'h0008);
    check("op3_exec_valid", exec_valid, 1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    exp_pc = 8'h01;
    check("op3_pc", pc, exp_pc);
    check("op3_done_outs", {ctrl, exec_valid}, 0);
    check("op3_ready_again", instr_ready, 1);

    // illegal opcode 9
    issue(8'h90);
    exp_pc = 8'h02;
    check("ill9_pulse", illegal, 1);
    check("ill9_ctrl", ctrl, 0);
    check("ill9_exec_valid", exec_valid, 0);
    check("ill9_pc", pc, exp_pc);
    tick();
    check("ill9_pulse_end", illegal, 0);
    check("ill9_exec_valid2", exec_valid, 0);

    // illegal opcode E
    issue(8'hE5);
    exp_pc = 8'h03;
    check("illE_pulse", illegal, 1);
    check("illE_pc", pc, exp_pc);

    // jump to 7
    issue(8'hB7);
    check("jmp_ctrl", ctrl, 14'h0400);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    exp_pc = 8'h07;
    check("jmp_pc", pc, exp_pc);

    // opcode C held in EXECUTE; instr_valid ignored there
    issue(8'hC3);
    instr_valid = 1'b1; instr_data = 8'h10;
    repeat (3) tick();
    check("hold_ctrl", ctrl, 14'h0800);
    check("hold_exec_valid", exec_valid, 1);
    check("hold_not_ready", instr_ready, 0);
    instr_valid = 1'b0;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    exp_pc = 8'h08;
    check("hold_pc", pc, exp_pc);

    // exec_done ignored in FETCH
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("done_in_fetch_pc", pc, exp_pc);

    // Opcode A, D, 8 control bits
    issue(8'hA0);
    check("opA_ctrl", ctrl, 14'h0200);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    issue(8'hD0);
    check("opD_ctrl", ctrl, 14'h1000);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    issue(8'h80);
    check("op8_ctrl", ctrl, 14'h0100);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    exp_pc = 8'h0B;
    check("three_ops_pc", pc, exp_pc);

    // 244 opcode-0 instructions at 3 cycles each bring pc to FF
    for (int i = 0; i < 244; i++) begin
      issue(8'h00);
      exec_done = 1'b1; tick(); exec_done = 1'b0;
    end
    exp_pc = 8'hFF;
    check("pc_ff", pc, exp_pc);
    issue(8'h20);
    check("op2_ctrl", ctrl, 14'h0004);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    exp_pc = 8'h00;
    check("pc_wrap", pc, exp_pc);

    // HALT
    issue(8'hF0);
    check("halt_halted", halted, 1);
    check("halt_ctrl13", ctrl, 14'h2000);
    check("halt_exec_valid", exec_valid, 0);
    instr_valid = 1'b1; instr_data = 8'h30;
    exec_done = 1'b1;
    tick();
    check("halt_ctrl_clear", ctrl, 0);
    for (int i = 0; i < 10; i++) begin
      check("halt_not_ready", instr_ready, 0);
      tick();
    end
    exec_done = 1'b0;
    check("halt_still", halted, 1);
    check("halt_pc_hold", pc, exp_pc);
    resume = 1'b1;
    tick();
    resume = 1'b0; instr_valid = 1'b0;
    exp_pc = 8'h01;
    check("resume_halted", halted, 0);
    check("resume_pc", pc, exp_pc);
    check("resume_ready", instr_ready, 1);

    // resume outside HALT is ignored
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_fetch_pc", pc, exp_pc);
    check("resume_fetch_ready", instr_ready, 1);

    // long EXECUTE with exec_done held low
    issue(8'h50);
    check("op5_ctrl", ctrl, 14'h0020);
`ifdef SEQ_TIMEOUT_EN
    repeat (14) tick();
    check("to_before_valid", exec_valid, 1);
    check("to_before_illegal", illegal, 0);
    tick();
    exp_pc = 8'h02;
    check("to_abort_valid", exec_valid, 0);
    check("to_abort_ctrl", ctrl, 0);
    check("to_abort_illegal", illegal, 1);
    check("to_abort_pc", pc, exp_pc);
`else
    repeat (100) tick();
    check("no_to_valid", exec_valid, 1);
    check("no_to_ctrl", ctrl, 14'h0020);
    check("no_to_illegal", illegal, 0);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    exp_pc = 8'h02;
    check("no_to_pc", pc, exp_pc);
`endif

    // reset in the second EXECUTE cycle
    issue(8'h40);
    check("op4_ctrl", ctrl, 14'h0010);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", ctrl, 0);
    check("midrst_outs", {exec_valid, halted, illegal}, 0);
    check("midrst_pc", pc, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", instr_ready, 1);
    check("midrst_pc_after", pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter width in bits.
REQ-002 SHALL have parameter EXEC_TIMEOUT, default 15, maximum EXECUTE cycles before abort (used only with SEQ_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port instr_valid  input  1  instruction word on instr_data is valid.
REQ-006 SHALL have port instr_data  input  8  [7:4] opcode, [3:0] operand.
REQ-007 SHALL have port instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-008 SHALL have port pc  output  PC_W  address of the instruction being fetched or executed.
REQ-009 SHALL have port ctrl  output  14  registered one-hot control word for the execution unit.
REQ-010 SHALL have port exec_valid  output  1  ctrl is valid, execution in progress.
REQ-011 SHALL have port exec_done  input  1  execution unit finished current instruction.
REQ-012 SHALL have port resume  input  1  leave HALT.
REQ-013 SHALL have port halted  output  1  sequencer in HALT state.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse: illegal opcode or timeout abort.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXECUTE, HALT, encoded in 2 bits.
REQ-016 SHALL drive instr_ready high only in FETCH; transfer occurs when instr_valid and instr_ready are both high, latching instr_data and moving to DECODE next cycle.
REQ-017 SHALL ignore instr_valid in every state other than FETCH.
REQ-018 SHALL in DECODE map opcode to ctrl index: 0-8 -> bits 0-8, 4'hA -> 9, 4'hB -> 10, 4'hC -> 11, 4'hD -> 12, 4'hF -> 13; exactly one ctrl bit SHALL be set.
REQ-019 SHALL treat opcodes 4'h9 and 4'hE as illegal: ctrl stays zero, illegal pulses for one cycle, pc increments, next state FETCH.
REQ-020 SHALL treat opcode 4'hF as HALT: ctrl[13] set for the DECODE->HALT transition cycle only, next state HALT, exec_valid not asserted.
REQ-021 SHALL for other legal opcodes enter EXECUTE with ctrl registered and exec_valid high, holding both stable until exec_done is sampled high.
REQ-022 SHALL on exec_done in EXECUTE clear ctrl and exec_valid, update pc, return to FETCH next cycle; exec_done in the first EXECUTE cycle SHALL be honoured.
REQ-023 SHALL ignore exec_done outside EXECUTE.
REQ-024 SHALL update pc as pc+1 modulo 2^PC_W, except opcode 4'hB (jump) which SHALL load pc with zero-extended operand on completion.
REQ-025 SHALL wrap pc from 2^PC_W-1 to 0 without error indication.
REQ-026 SHALL drive halted high in HALT; resume high in HALT SHALL increment pc and enter FETCH next cycle; resume in other states ignored.
REQ-027 SHALL yield one instruction per minimum 3 cycles (FETCH, DECODE, EXECUTE with immediate exec_done).

Reset
REQ-028 SHALL on rst_n low asynchronously force state FETCH, pc 0, ctrl 0, exec_valid 0, halted 0, illegal 0, latched instruction 0.
REQ-029 SHALL drive instr_ready high in the first cycle after rst_n deasserts.
REQ-030 SHALL abandon any instruction in progress when reset asserts mid-EXECUTE; no pc update occurs.

Configuration
REQ-031 SHALL, with macro SEQ_TIMEOUT_EN defined, count EXECUTE cycles; if exec_done is not seen within EXEC_TIMEOUT cycles, clear ctrl and exec_valid, pulse illegal, increment pc, return to FETCH.
REQ-032 SHALL, with SEQ_TIMEOUT_EN undefined, omit the counter and wait in EXECUTE indefinitely; EXEC_TIMEOUT has no effect.
REQ-033 SHALL give exec_done priority over timeout when both occur in the same cycle.

Verification
REQ-034 Reset then instr_data 8'h30 valid, exec_done one cycle after exec_valid -> ctrl 14'h0008 during EXECUTE, pc 0 -> 1, instr_ready high again.
REQ-035 instr_data 8'h90 -> illegal one-cycle pulse in DECODE, ctrl stays 0, exec_valid never high, pc +1.
REQ-036 instr_data 8'hB7 with exec_done -> ctrl 14'h0400, pc becomes 8'h07; pc 8'hFF plus 8'h20 -> pc 8'h00.
REQ-037 instr_data 8'hF0 -> halted high, instr_ready low for 10 cycles with instr_valid high; resume pulse -> halted low, pc +1, FETCH.
REQ-038 SEQ_TIMEOUT_EN defined, EXEC_TIMEOUT 15, exec_done held low -> abort after 15 EXECUTE cycles, illegal pulse, pc +1; undefined -> exec_valid remains high after 100 cycles.
REQ-039 rst_n low in second EXECUTE cycle -> all outputs zero immediately, pc 0, instr_ready high after release.
